// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle multiply / multiply-accumulate / divide
// on magnitudes, with sign correction and accumulation applied in a final FIX step.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic [2*WIDTH-1:0] acc_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_by_zero_o
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t             state;
   logic [CW-1:0]      cnt;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a, b;
   logic [2*WIDTH-1:0] acc, p;
   logic               neg_res, neg_rem, dz;
   logic               sgn_in, div_in, is_div;
   logic [WIDTH-1:0]   mag1, mag2, q, r;
   logic [WIDTH:0]     msum, rt, diff;
   logic [2*WIDTH-1:0] prod, mres;
   assign sgn_in = ~op_i[0];
   assign div_in = ~op_i[2] & op_i[1];
   assign is_div = ~op_r[1] & op_r[0];
   assign mag1   = (sgn_in && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign mag2   = (sgn_in && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   // p holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign msum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
   assign rt     = p[2*WIDTH-1:WIDTH-1];
   assign diff   = rt - {1'b0, b};
   assign prod   = neg_res ? -p : p;
   assign q      = neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0];
   assign r      = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
   assign mres   = !op_r[1] ? prod : (op_r[0] ? acc - prod : acc + prod);
   assign busy_o = state != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         op_r          <= '0;
         a             <= '0;
         b             <= '0;
         acc           <= '0;
         p             <= '0;
         neg_res       <= 1'b0;
         neg_rem       <= 1'b0;
         dz            <= 1'b0;
         result_o      <= '0;
         ready_o       <= 1'b0;
         div_by_zero_o <= 1'b0;
      end else begin
         ready_o       <= 1'b0;
         div_by_zero_o <= 1'b0;
         case (state)
            IDLE: if (start_i && !annul_i) begin
               op_r    <= op_i[2:1];
               acc     <= acc_i;
               cnt     <= '0;
               a       <= mag1;
               b       <= mag2;
               p       <= div_in ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
               neg_res <= sgn_in & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               neg_rem <= sgn_in & opdata1_i[WIDTH-1];
               dz      <= div_in && opdata2_i == '0;
               if (div_in && opdata2_i == '0) begin
                  result_o <= '0;
                  state    <= DONE;
               end else begin
                  state    <= CALC;
               end
            end
            CALC: if (annul_i) state <= IDLE;
            else begin
               p     <= is_div ? {(diff[WIDTH] ? rt[WIDTH-1:0] : diff[WIDTH-1:0]), p[WIDTH-2:0], ~diff[WIDTH]}
                               : {msum, p[WIDTH-1:1]};
               cnt   <= cnt + CW'(1);
               state <= cnt == CW'(WIDTH - 1) ? FIX : CALC;
            end
            FIX: if (annul_i) state <= IDLE;
            else begin
               result_o <= is_div ? {r, q} : mres;
               state    <= DONE;
            end
            default: begin
               ready_o       <= !annul_i;
               div_by_zero_o <= dz & !annul_i;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be even and >= 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request; SHALL be sampled only in IDLE.
REQ-005 annul_i  input  1  abort of the in-flight operation (flush/exception).
REQ-006 op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-007 opdata1_i  input  WIDTH  multiplicand or dividend.
REQ-008 opdata2_i  input  WIDTH  multiplier or divisor.
REQ-009 acc_i  input  2*WIDTH  current {HI,LO}; used by MADD/MSUB.
REQ-010 result_o  output  2*WIDTH  {HI,LO} result.
REQ-011 ready_o  output  1  one-cycle result-valid pulse.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 div_by_zero_o  output  1  qualifies ready_o for a DIV or DIVU with divisor 0.

Function
REQ-014 States SHALL be IDLE, CALC, FIX and DONE, with a log2(WIDTH)+1-bit iteration counter.
REQ-015 IDLE, start_i=1, annul_i=0, divide op, opdata2_i=0: next state DONE, div_by_zero_o=1 in DONE, result_o=0.
REQ-016 IDLE, start_i=1, annul_i=0, otherwise: register op_i and acc_i; register operands as magnitudes for signed ops (MULT, DIV, MADD, MSUB) and unchanged for unsigned ops; record the result signs; counter=0; next state CALC.
REQ-017 CALC SHALL resolve one bit per cycle: multiply by shift-add into a 2*WIDTH accumulator, divide by restoring shift-subtract; after counter reaches WIDTH-1, next state FIX.
REQ-018 FIX SHALL apply sign correction and accumulation, load result_o, then go to DONE.
REQ-019 DONE SHALL assert ready_o for exactly one cycle, then go to IDLE.
REQ-020 Latency: start sampled at edge 0 -> ready_o high in the cycle after edge WIDTH+2; divide-by-zero -> ready_o high in the cycle after edge 1.
REQ-021 MULT/MULTU: result_o = full 2*WIDTH product; signed product negated when operand signs differ.
REQ-022 MADD/MADDU: result_o = acc + product, modulo 2^(2*WIDTH); MSUB/MSUBU: result_o = acc - product, modulo 2^(2*WIDTH); acc is the value captured at start.
REQ-023 DIV/DIVU: result_o = {remainder, quotient}; signed quotient negated when signs differ; signed remainder takes the dividend's sign.
REQ-024 DIV of most-negative by -1: quotient = most-negative (wraps), remainder = 0, div_by_zero_o=0.
REQ-025 result_o SHALL hold its value from load until the next FIX or reset; it SHALL NOT change on annul.
REQ-026 start_i while busy_o=1 SHALL be ignored; opdata/acc input changes after acceptance SHALL have no effect.
REQ-027 annul_i=1 in CALC, FIX or DONE: next state IDLE; ready_o SHALL stay 0 from that edge onward; result_o is unchanged.
REQ-028 annul_i=1 together with start_i=1 in IDLE: request rejected, remain IDLE.
REQ-029 start_i may be accepted in the cycle immediately after DONE, giving back-to-back operation.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, counter 0, result_o 0, ready_o 0, busy_o 0, div_by_zero_o 0, internal operand/accumulator registers 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; no ready_o pulse follows the release of reset.
REQ-032 After rst returns to 1, the first rising edge SHALL be able to accept start_i.

Verification (WIDTH=32)
REQ-033 MULT 0xFFFFFFFD x 0x00000005 -> result_o 0xFFFFFFFF_FFFFFFF1, ready_o in the cycle after edge 34, busy_o high for cycles 1-34.
REQ-034 DIVU 100 / 7 -> result_o 0x00000002_0000000E; DIV 0xFFFFFFF9 / 2 -> result_o 0xFFFFFFFF_FFFFFFFD.
REQ-035 MSUB acc 0x00000000_0000000A, 3 x 4 -> result_o 0xFFFFFFFF_FFFFFFFE; MADDU acc 0xFFFFFFFF_FFFFFFFF, 1 x 1 -> result_o 0.
REQ-036 DIV 0x80000000 / 0 -> ready_o and div_by_zero_o high in the cycle after edge 1, result_o 0; DIV 0x80000000 / 0xFFFFFFFF -> result_o 0x00000000_80000000.
REQ-037 MULTU started, annul_i pulsed at cycle 10 -> busy_o low from cycle 11, no ready_o, result_o unchanged; a new start at cycle 11 is accepted.
REQ-038 rst pulsed low at cycle 15 of a DIVU -> all outputs 0 immediately, no ready_o afterwards; back-to-back MULTs complete 35 cycles apart.
